// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - bin one bit per clock, LSB first,
// and presents {borrow_out, difference} on out with a one-cycle done pulse.
module serial_subtractor #(
  parameter int NO_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NO_BITS-1:0] A,
  input  logic [NO_BITS-1:0] B,
  input  logic               bin,
  output logic               ready,
  output logic               done,
  output logic [NO_BITS:0]   out
);

  localparam int CW = (NO_BITS > 2) ? $clog2(NO_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NO_BITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic                 accept;
  logic [CW-1:0]        cnt;
  logic [NO_BITS-1:0]   a_sh, b_sh;
  logic [NO_BITS-2:0]   diff_sh;
  logic [NO_BITS-1:0]   diff_nxt;
  logic                 br;
  logic                 br_nxt;
  logic                 d_bit;
  logic                 last_bit;

  // One-bit full subtractor: returns {borrow_next, difference_bit}.
  function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic bi);
    sub_bit = {(~a & b) | (~(a ^ b) & bi), a ^ b ^ bi};
  endfunction

  assign {br_nxt, d_bit} = sub_bit(a_sh[0], b_sh[0], br);
  assign diff_nxt        = {d_bit, diff_sh};
  assign last_bit        = (cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter and result register; out only moves on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      out <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (last_bit) out <= {br_nxt, diff_nxt};
    end
  end

  // Operand shifters, running borrow and partial difference.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= A;
      b_sh <= B;
      br   <= bin;
    end else if (state == RUN) begin
      a_sh    <= {1'b0, a_sh[NO_BITS-1:1]};
      b_sh    <= {1'b0, b_sh[NO_BITS-1:1]};
      br      <= br_nxt;
      diff_sh <= diff_nxt[NO_BITS-1:1];
    end
  end

endmodule
